// File: rtl/pwr_btn_debounce_pkg.sv
// Shared power-sequencing types and timing defaults for the front-panel button path.
// Defaults are also used by the sequencer timeouts, so change them here only.
package pwr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_t;

  localparam int MS_CNT_W              = 13;
  localparam int DEFAULT_DEBOUNCE_MS   = 16;
  localparam int DEFAULT_LONG_PRESS_MS = 4000;

endpackage

// File: rtl/pwr_btn_debounce_if.sv
// Button conditioning bus: tick and raw pin in, debounced level and press strobes out.
// master drives the inputs (board/bench side), slave is the conditioning block.
interface pwr_btn_debounce_if;
  import pwr_seq_pkg::*;

  logic tick_1ms;
  logic btn_raw_n;
  logic btn_db_n;
  logic press_n;
  logic long_press;
  logic short_release;
  logic hold_active;

  modport master (
    output tick_1ms, btn_raw_n,
    input  btn_db_n, press_n, long_press, short_release, hold_active
  );

  modport slave (
    input  tick_1ms, btn_raw_n,
    output btn_db_n, press_n, long_press, short_release, hold_active
  );

endinterface

// File: rtl/pwr_btn_debounce_filter.sv
// 2-flop synchroniser plus ms-tick stability filter; the level only moves after
// DEBOUNCE_MS consecutive ticks of disagreement. Also used for reset and intrusion inputs.
module debounce_filter
  import pwr_seq_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_1ms,
  input  logic btn_raw_n,
  output logic btn_db_n
);

  localparam logic [7:0] STABLE_LAST = 8'(DEBOUNCE_MS - 1);

  logic       sync_q;
  logic       sync_n;
  logic [7:0] stable_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 1'b1;
      sync_n     <= 1'b1;
      btn_db_n   <= 1'b1;
      stable_cnt <= '0;
    end else begin
      sync_q <= btn_raw_n;
      sync_n <= sync_q;
      // Mismatch is judged on the current sync_n, so a tick arriving with the edge counts.
      if (sync_n == btn_db_n) begin
        stable_cnt <= '0;
      end else if (tick_1ms) begin
        if (stable_cnt == STABLE_LAST) begin
          btn_db_n   <= sync_n;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pwr_btn_debounce.sv
// Power button front end: debounce, short/long press classification, press strobe
// for the power-sequence one-shot and long-press flag for forced power-off.
module pwr_btn_debounce
  import pwr_seq_pkg::*;
#(
  parameter int DEBOUNCE_MS   = DEFAULT_DEBOUNCE_MS,
  parameter int LONG_PRESS_MS = DEFAULT_LONG_PRESS_MS,
  parameter int CNT_W         = MS_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  pwr_btn_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_MS - 1);

  logic             db_n;
  logic             db_prev;
  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic             press_n_q;
  logic             long_press_q;
  logic             short_release_q;
  logic             hold_active_q;

  debounce_filter #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1ms (bus.tick_1ms),
    .btn_raw_n(bus.btn_raw_n),
    .btn_db_n (db_n)
  );

  // Release is tested before the long threshold so a coincident release stays short.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (db_prev && !db_n) state_nxt = PRESSED;
      PRESSED: begin
        if (db_n)                                 state_nxt = IDLE;
        else if (bus.tick_1ms && hold_cnt == LONG_LAST) state_nxt = LONG_HELD;
      end
      LONG_HELD: if (db_n) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev         <= 1'b1;
      state           <= IDLE;
      hold_cnt        <= '0;
      press_n_q       <= 1'b1;
      long_press_q    <= 1'b0;
      short_release_q <= 1'b0;
      hold_active_q   <= 1'b0;
    end else begin
      db_prev         <= db_n;
      state           <= state_nxt;
      hold_active_q   <= (state_nxt != IDLE);
      press_n_q       <= !(state == IDLE && state_nxt == PRESSED);
      long_press_q    <= (state == PRESSED && state_nxt == LONG_HELD);
      short_release_q <= (state == PRESSED && state_nxt == IDLE);
      // Counter only runs in PRESSED, so it freezes once LONG_HELD is reached.
      if (state == IDLE)
        hold_cnt <= '0;
      else if (state == PRESSED && bus.tick_1ms)
        hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  assign bus.btn_db_n      = db_n;
  assign bus.press_n       = press_n_q;
  assign bus.long_press    = long_press_q;
  assign bus.short_release = short_release_q;
  assign bus.hold_active   = hold_active_q;

endmodule

// File: tb/tb_pwr_btn_debounce.sv
// Directed bench for pwr_btn_debounce with DEBOUNCE_MS=4, LONG_PRESS_MS=10, tick every 10 clk.
// A monitor counts strobes and edges; checks compare count deltas against hand-derived values.
module tb_pwr_btn_debounce;

  logic clk = 1'b0;
  logic rst_n;

  pwr_btn_debounce_if bus ();

  pwr_btn_debounce #(
    .DEBOUNCE_MS  (4),
    .LONG_PRESS_MS(10),
    .CNT_W        (13)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Free-running tick: one clk high out of every ten, changed on the falling edge.
  int tdiv = 0;
  initial begin
    bus.tick_1ms = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv == 9) ? 0 : tdiv + 1;
      bus.tick_1ms = (tdiv == 9);
    end
  end

  int   cyc = 0, tick_cnt = 0;
  int   n_press = 0, n_long = 0, n_short = 0, n_rise = 0, n_fall = 0;
  int   press_tick = 0, long_tick = 0, cyc_short = 0, cyc_rise = 0;
  logic db_prev_m = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.tick_1ms) tick_cnt++;
    if (!bus.press_n) begin n_press++; press_tick = tick_cnt; end
    if (bus.long_press) begin n_long++; long_tick = tick_cnt; end
    if (bus.short_release) begin n_short++; cyc_short = cyc; end
    if (bus.btn_db_n && !db_prev_m) begin n_rise++; cyc_rise = cyc; end
    if (!bus.btn_db_n && db_prev_m) n_fall++;
    db_prev_m = bus.btn_db_n;
  end

  int b_press, b_long, b_short, b_rise, b_fall;

  task automatic snap();
    b_press = n_press; b_long = n_long; b_short = n_short;
    b_rise  = n_rise;  b_fall = n_fall;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.btn_raw_n = 1'b0;

    // 1: reset values with the button held, then a fresh press after release of reset
    wait_clk(3);
    check("rst_db_n",     bus.btn_db_n, 1);
    check("rst_press_n",  bus.press_n, 1);
    check("rst_long",     bus.long_press, 0);
    check("rst_short",    bus.short_release, 0);
    check("rst_hold",     bus.hold_active, 0);
    snap();
    rst_n = 1'b1;
    wait_clk(60);
    check("t1_db_low",    bus.btn_db_n, 0);
    check("t1_press_cnt", n_press - b_press, 1);
    check("t1_hold",      bus.hold_active, 1);
    check("t1_no_long",   n_long - b_long, 0);
    bus.btn_raw_n = 1'b1;
    wait_clk(60);
    check("t1_short_cnt", n_short - b_short, 1);
    check("t1_db_high",   bus.btn_db_n, 1);
    check("t1_hold_off",  bus.hold_active, 0);

    // 2: glitch shorter than the filter window
    snap();
    bus.btn_raw_n = 1'b0;
    wait_clk(25);
    bus.btn_raw_n = 1'b1;
    wait_clk(60);
    check("t2_db_fall",   n_fall - b_fall, 0);
    check("t2_press",     n_press - b_press, 0);
    check("t2_short",     n_short - b_short, 0);
    check("t2_hold",      bus.hold_active, 0);

    // 3: short press, short_release one clk after the debounced release
    snap();
    bus.btn_raw_n = 1'b0;
    wait_clk(80);
    bus.btn_raw_n = 1'b1;
    wait_clk(60);
    check("t3_press",     n_press - b_press, 1);
    check("t3_short",     n_short - b_short, 1);
    check("t3_long",      n_long - b_long, 0);
    check("t3_short_lag", cyc_short - cyc_rise, 1);
    check("t3_db_high",   bus.btn_db_n, 1);

    // 4: long press, long_press exactly ten ticks after the press strobe
    snap();
    bus.btn_raw_n = 1'b0;
    wait_clk(200);
    check("t4_press",     n_press - b_press, 1);
    check("t4_long",      n_long - b_long, 1);
    check("t4_long_ticks", long_tick - press_tick, 10);
    check("t4_hold",      bus.hold_active, 1);
    bus.btn_raw_n = 1'b1;
    wait_clk(60);
    check("t4_no_short",  n_short - b_short, 0);
    check("t4_hold_off",  bus.hold_active, 0);
    check("t4_long_once", n_long - b_long, 1);

    // 5: contact bounce on release
    snap();
    bus.btn_raw_n = 1'b0;
    wait_clk(50);
    for (int i = 0; i < 12; i++) begin
      bus.btn_raw_n = ~bus.btn_raw_n;
      wait_clk(5);
    end
    bus.btn_raw_n = 1'b1;
    wait_clk(60);
    check("t5_db_fall",   n_fall - b_fall, 1);
    check("t5_db_rise",   n_rise - b_rise, 1);
    check("t5_press",     n_press - b_press, 1);
    check("t5_one_end",   (n_short - b_short) + (n_long - b_long), 1);
    check("t5_hold_off",  bus.hold_active, 0);

    // 6: reset in the middle of a hold, button still down afterwards
    snap();
    bus.btn_raw_n = 1'b0;
    for (int i = 0; i < 100 && !bus.hold_active; i++) wait_clk(1);
    check("t6_hold_wait", bus.hold_active, 1);
    wait_clk(50);
    check("t6_hold_mid",  bus.hold_active, 1);
    check("t6_no_long",   n_long - b_long, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_hold",  bus.hold_active, 0);
    check("t6_rst_press", bus.press_n, 1);
    check("t6_rst_db",    bus.btn_db_n, 1);
    wait_clk(3);
    snap();
    rst_n = 1'b1;
    wait_clk(60);
    check("t6_repress",   n_press - b_press, 1);
    check("t6_db_low",    bus.btn_db_n, 0);
    check("t6_hold_again", bus.hold_active, 1);
    bus.btn_raw_n = 1'b1;
    wait_clk(60);
    check("t6_release",   bus.hold_active, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pwr_btn_debounce.md
Name: pwr_btn_debounce

Overview:
Front-end conditioning stage for the front-panel power button.
- Synchronises and debounces the raw button input against the shared free-running 1 ms tick.
- Classifies each press as short or long.
- Drives an active-low one-clock press strobe. This strobe is the trigger input of the downstream one-shot pulse generator in the power-sequence path.
- The long-press indication feeds the forced power-off logic.

Parameters:
DEBOUNCE_MS, 16, number of consecutive 1 ms ticks the synchronised input must be stable before the debounced level changes; legal 1..255
LONG_PRESS_MS, 4000, hold time in ms, measured from the debounced press, at which long_press fires; legal > DEBOUNCE_MS, max 8191
CNT_W, 13, width of the hold counter; must hold LONG_PRESS_MS

Ports:
clk  input  1  CPLD clock
rst_n  input  1  asynchronous active-low reset
tick_1ms  input  1  one-clk-wide strobe every 1 ms from the shared free-running counter
btn_raw_n  input  1  raw asynchronous button pin, low = pressed
btn_db_n  output  1  debounced button level, low = pressed
press_n  output  1  active-low one-clk strobe on each debounced press; drives the one-shot trigger
long_press  output  1  one-clk high strobe when the hold reaches LONG_PRESS_MS
short_release  output  1  one-clk high strobe on release before LONG_PRESS_MS
hold_active  output  1  high while in PRESSED or LONG_HELD

Behaviour:
Reset (async, rst_n low):
- Synchroniser flops = 1, btn_db_n = 1, press_n = 1.
- long_press = 0, short_release = 0, hold_active = 0.
- State = IDLE; both counters = 0.
- All outputs are registered.

Synchroniser:
- 2-flop chain on btn_raw_n. sync_n lags the pin by 2 clk.

Debounce filter:
- sync_n == btn_db_n: stable counter cleared every clk.
- sync_n != btn_db_n: counter increments on each tick_1ms.
- When the counter equals DEBOUNCE_MS-1 and tick_1ms is high, btn_db_n <= sync_n at that edge and the counter clears.
- A mismatch that disappears before that tick clears the counter. Glitches shorter than DEBOUNCE_MS-1 ticks never propagate.
- A change of sync_n in the same clk as tick_1ms: the tick is evaluated against the new mismatch condition, i.e. it counts.
- Worst-case latency: 2 clk + DEBOUNCE_MS ms.

Classifier FSM (encoding in package):
- IDLE: btn_db_n falling (registered previous value 1, current 0) -> PRESSED. Hold counter <= 0.
- PRESSED:
  - On each tick_1ms, hold counter +1.
  - Hold counter == LONG_PRESS_MS-1 with tick -> LONG_HELD.
  - Release (btn_db_n high) -> IDLE.
  - Release and long threshold in the same clk: release wins -> IDLE with short_release, no long_press.
- LONG_HELD: hold counter frozen (saturates); btn_db_n high -> IDLE.

Output timing:
- press_n is low for exactly the one clk following the IDLE->PRESSED transition edge.
- long_press is high for the one clk after entering LONG_HELD.
- short_release is high for the one clk after PRESSED->IDLE.
- Release from LONG_HELD produces no strobe.
- hold_active = (state != IDLE), registered.

Other rules:
- No re-trigger: a new press_n needs a full debounced release and then a new debounced press.
- tick_1ms stuck high: counters advance every clk; no special handling.
- Reset mid-press: immediate return to IDLE with all outputs at reset value. Button still held at reset release: after debounce, btn_db_n goes low and produces a fresh press_n.

Decomposition:
- Package pwr_seq_pkg:
  - btn_state_t enum (IDLE, PRESSED, LONG_HELD), 2-bit.
  - MS_CNT_W constant.
  - Default DEBOUNCE_MS/LONG_PRESS_MS constants, shared with the sequencer timeouts.
- Sub-module debounce_filter (synchroniser + stable counter + btn_db_n register, parameter DEBOUNCE_MS). It is reused for the reset-button and chassis-intrusion inputs.
- Top level holds the FSM, hold counter and strobes.

Test Plan:
Common bench setup: DEBOUNCE_MS=4, LONG_PRESS_MS=10, tick_1ms every 10 clk.
1. Reset check: assert rst_n low for 3 clk with btn_raw_n=0 -> all outputs at reset values. After release and 4 ticks: btn_db_n=0, one press_n low clk, hold_active=1.
2. Glitch rejection: btn_raw_n low for 25 clk (2 ticks), then high -> btn_db_n stays 1; no strobes.
3. Short press: low for 80 clk, then high -> one press_n pulse; short_release one clk after debounced release; long_press never asserted.
4. Long press: hold low for 200 clk -> long_press exactly once, 10 ticks after the press_n strobe. Release -> no short_release; hold_active drops.
5. Bounce on release: toggle the pin every 5 clk for 60 clk after a held press -> btn_db_n changes once; single short_release or none.
6. Reset mid-hold: rst_n low while in PRESSED after 5 ticks -> hold_active=0 immediately. Pin still low after reset -> a new press_n fires after 4 ticks.
